mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory-controller command port between two requesters, e.g. the Mandelbrot compute engine (requester 0) and the colour/pixel-copy engine (requester 1).
- Gates all traffic on memory calibration and arbitrates round-robin.
- Issues exactly one command per grant, honours cmd_full, and holds the grant until the owner reports its data phase complete.
- Sits between the requester engines and the memory command FIFO; the read/write data FIFOs stay wired directly to their engines.

Parameters:
- ADDR_W, 30: byte-address width of the command port.
- BL_W, 6: burst-length field width (burst length minus 1).
- HOLD_MAX, 4096: maximum cycles a grant may be held in HOLD before forced release.
- HOLD_CW, 13: width of the hold counter; must satisfy 2^HOLD_CW > HOLD_MAX.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- mem_calib_done  in  1  memory calibration complete; asynchronous to clk.
- cmd_full  in  1  memory command FIFO full.
- req  in  2  per-requester request level.
- req_instr  in  6  {instr1[2:0], instr0[2:0]}; 000 = write, 001 = read.
- req_bl  in  2*BL_W  {bl1, bl0}.
- req_addr  in  2*ADDR_W  {addr1, addr0}.
- req_done  in  2  per-requester single-cycle pulse: data phase complete.
- grant  out  2  one-hot ownership; all zero when idle.
- cmd_issued  out  2  one-cycle pulse to the owner in the cycle its cmd_en pulses.
- cmd_instr  out  3  to the memory controller.
- cmd_bl  out  BL_W  to the memory controller.
- cmd_byte_addr  out  ADDR_W  to the memory controller.
- cmd_en  out  1  command strobe.
- timeout_err  out  1  sticky: a grant was force-released.
- align_err  out  1  sticky: a latched address had addr[1:0] != 0.
- state_dbg  out  2  current state, for LEDs.

Behaviour:
- Reset (reset = 0, asynchronous): state = WAIT_CAL.
  - grant, cmd_issued, cmd_en, cmd_instr, cmd_bl and cmd_byte_addr all 0.
  - timeout_err and align_err 0; last_owner = 1, so requester 0 wins the first tie.
  - Hold counter 0; calibration synchroniser flops 0.
  - Reset mid-command: cmd_en drops immediately; no completion pulse is generated.
- mem_calib_done passes through a 2-flop synchroniser (calib_s). All decisions use calib_s.
- State encoding: WAIT_CAL = 0, IDLE = 1, ISSUE = 2, HOLD = 3. state_dbg mirrors the state register.
- WAIT_CAL: move to IDLE when calib_s = 1. Requests are ignored until then.
- IDLE:
  - If calib_s = 0, return to WAIT_CAL.
  - Else if any req bit is set, choose the winner W:
    - Only one requester requesting: that requester wins.
    - Both requesting: W = !last_owner.
  - At the clock edge: grant[W] = 1; cmd_instr/cmd_bl/cmd_byte_addr latch W's fields with cmd_byte_addr[1:0] forced to 0; go to ISSUE.
  - If the supplied addr[1:0] != 0, align_err sets.
  - Requesters may drop req freely before they are granted.
- ISSUE:
  - If cmd_full = 0: cmd_en = 1 and cmd_issued[W] = 1 for exactly one cycle (registered); go to HOLD; clear the hold counter.
  - If cmd_full = 1: stay in ISSUE, cmd_en stays 0, command fields stay stable.
- Latency: req sampled in IDLE at cycle N → grant and fields at N+1 → cmd_en at N+2 when cmd_full = 0.
- cmd_* fields remain stable from latch until the next grant.
- HOLD:
  - The hold counter increments each cycle.
  - req_done[W] = 1: grant becomes 0, last_owner = W, go to IDLE. Re-arbitration takes one idle cycle, so the earliest next cmd_en is 3 cycles after done.
  - Counter reaches HOLD_MAX - 1 with no done: force release as above; timeout_err sets (sticky until reset).
  - req_done from the non-owner is ignored. The owner's req level is ignored while in HOLD.
  - Done in the same cycle as the timeout: treated as a normal release; timeout_err does not set.
- calib_s falling outside IDLE: the current transaction completes, then IDLE moves to WAIT_CAL.
- cmd_en never asserts while cmd_full = 1 was sampled in that ISSUE cycle. The two grant bits are never both 1.

Test Plan:
- Calibration gating: req = 01 with mem_calib_done = 0 for 20 cycles → grant = 00, cmd_en never pulses. Raise calib → grant = 01 within 4 cycles; cmd_en pulses once with cmd_byte_addr = addr0.
- Round-robin fairness: req = 11 held continuously, each owner pulses done 5 cycles after cmd_issued → grants alternate 01, 10, 01, 10; cmd_instr/cmd_bl/cmd_byte_addr match the owner each time.
- Backpressure: cmd_full = 1 for 7 cycles in ISSUE → cmd_en stays 0, fields stable. cmd_full falls → exactly one cmd_en pulse on the next cycle.
- Timeout: HOLD_MAX = 16, owner never sends done → grant drops 16 cycles after cmd_en, timeout_err = 1; the next requester is then granted normally.
- Alignment and bad done: addr0 = 0x103 → cmd_byte_addr = 0x100, align_err = 1. req_done[1] while requester 0 owns → no release.
- Async reset in HOLD: pull reset low mid-cycle → grant = 00, cmd_en = 0, state_dbg = 0 immediately. After release, a 2-cycle calibration resync precedes the first grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single memory-controller command port.
// Gated on synchronised calibration; one command per grant; grant held until done or timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned BL_W     = 6,
  parameter int unsigned HOLD_MAX = 4096,
  parameter int unsigned HOLD_CW  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_calib_done,
  input  logic                  cmd_full,
  input  logic [1:0]            req,
  input  logic [5:0]            req_instr,
  input  logic [2*BL_W-1:0]     req_bl,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [1:0]            req_done,
  output logic [1:0]            grant,
  output logic [1:0]            cmd_issued,
  output logic [2:0]            cmd_instr,
  output logic [BL_W-1:0]       cmd_bl,
  output logic [ADDR_W-1:0]     cmd_byte_addr,
  output logic                  cmd_en,
  output logic                  timeout_err,
  output logic                  align_err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    IDLE     = 2'd1,
    ISSUE    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(HOLD_MAX - 1);

  state_t              state_q, state_d;
  logic                calib_meta_q, calib_meta_d;
  logic                calib_s_q, calib_s_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          cmd_issued_q, cmd_issued_d;
  logic                cmd_en_q, cmd_en_d;
  logic [2:0]          cmd_instr_q, cmd_instr_d;
  logic [BL_W-1:0]     cmd_bl_q, cmd_bl_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic                timeout_q, timeout_d;
  logic                align_q, align_d;
  logic                last_owner_q, last_owner_d;
  logic [HOLD_CW-1:0]  hold_cnt_q, hold_cnt_d;

  logic                win;
  logic                owner;
  logic [ADDR_W-1:0]   sel_addr;

  // Tie goes to whoever did not own the port last; a lone requester always wins.
  assign win      = (req == 2'b11) ? ~last_owner_q : req[1];
  assign owner    = grant_q[1];
  assign sel_addr = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];

  always_comb begin
    calib_meta_d = mem_calib_done;
    calib_s_d    = calib_meta_q;
    state_d      = state_q;
    grant_d      = grant_q;
    cmd_issued_d = '0;
    cmd_en_d     = 1'b0;
    cmd_instr_d  = cmd_instr_q;
    cmd_bl_d     = cmd_bl_q;
    cmd_addr_d   = cmd_addr_q;
    timeout_d    = timeout_q;
    align_d      = align_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      WAIT_CAL: begin
        if (calib_s_q) state_d = IDLE;
      end
      IDLE: begin
        if (!calib_s_q) begin
          state_d = WAIT_CAL;
        end else if (|req) begin
          grant_d     = win ? 2'b10 : 2'b01;
          cmd_instr_d = win ? req_instr[5:3] : req_instr[2:0];
          cmd_bl_d    = win ? req_bl[2*BL_W-1:BL_W] : req_bl[BL_W-1:0];
          cmd_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
          if (sel_addr[1:0] != 2'b00) align_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!cmd_full) begin
          cmd_en_d     = 1'b1;
          cmd_issued_d = grant_q;
          hold_cnt_d   = '0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_CW'(1);
        // A done arriving on the timeout cycle wins, so no error is flagged.
        if (req_done[owner] || (hold_cnt_q == HOLD_LAST)) begin
          if (!req_done[owner]) timeout_d = 1'b1;
          grant_d      = '0;
          last_owner_d = owner;
          state_d      = IDLE;
        end
      end
      default: state_d = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_CAL;
      calib_meta_q <= 1'b0;
      calib_s_q    <= 1'b0;
      grant_q      <= '0;
      cmd_issued_q <= '0;
      cmd_en_q     <= 1'b0;
      cmd_instr_q  <= '0;
      cmd_bl_q     <= '0;
      cmd_addr_q   <= '0;
      timeout_q    <= 1'b0;
      align_q      <= 1'b0;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      calib_meta_q <= calib_meta_d;
      calib_s_q    <= calib_s_d;
      grant_q      <= grant_d;
      cmd_issued_q <= cmd_issued_d;
      cmd_en_q     <= cmd_en_d;
      cmd_instr_q  <= cmd_instr_d;
      cmd_bl_q     <= cmd_bl_d;
      cmd_addr_q   <= cmd_addr_d;
      timeout_q    <= timeout_d;
      align_q      <= align_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign grant         = grant_q;
  assign cmd_issued    = cmd_issued_q;
  assign cmd_en        = cmd_en_q;
  assign cmd_instr     = cmd_instr_q;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign timeout_err   = timeout_q;
  assign align_err     = align_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents push expected commands,
// a monitor checks every cmd_en and every new grant against a round-robin model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W   = 30;
  localparam int unsigned BL_W     = 6;
  localparam int unsigned HOLD_MAX = 16;
  localparam int unsigned HOLD_CW  = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                mem_calib_done = 1'b0;
  logic                cmd_full = 1'b0;
  logic [1:0]          req = '0;
  logic [5:0]          req_instr = '0;
  logic [2*BL_W-1:0]   req_bl = '0;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [1:0]          req_done = '0;
  logic [1:0]          grant;
  logic [1:0]          cmd_issued;
  logic [2:0]          cmd_instr;
  logic [BL_W-1:0]     cmd_bl;
  logic [ADDR_W-1:0]   cmd_byte_addr;
  logic                cmd_en;
  logic                timeout_err;
  logic                align_err;
  logic [1:0]          state_dbg;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .BL_W    (BL_W),
    .HOLD_MAX(HOLD_MAX),
    .HOLD_CW (HOLD_CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_calib_done(mem_calib_done),
    .cmd_full      (cmd_full),
    .req           (req),
    .req_instr     (req_instr),
    .req_bl        (req_bl),
    .req_addr      (req_addr),
    .req_done      (req_done),
    .grant         (grant),
    .cmd_issued    (cmd_issued),
    .cmd_instr     (cmd_instr),
    .cmd_bl        (cmd_bl),
    .cmd_byte_addr (cmd_byte_addr),
    .cmd_en        (cmd_en),
    .timeout_err   (timeout_err),
    .align_err     (align_err),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        instr;
    logic [BL_W-1:0]   bl;
    logic [ADDR_W-1:0] addr;
  } txn_t;

  txn_t        exp_q0[$];
  txn_t        exp_q1[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Agent state and knobs
  bit          pending[2];
  bit          busy[2];
  bit          no_done[2];
  int unsigned cd[2];
  bit          auto_new = 1'b0;
  bit          refill   = 1'b0;
  int unsigned new_pct  = 0;
  int unsigned full_pct = 0;
  int unsigned dly_lo   = 2;
  int unsigned dly_hi   = 2;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic set_txn(input int unsigned i, input logic [2:0] instr,
                         input logic [BL_W-1:0] bl, input logic [ADDR_W-1:0] addr);
    txn_t t;
    t.instr = instr;
    t.bl    = bl;
    t.addr  = addr & ~ADDR_W'(3);
    if (i == 0) begin
      req_instr[2:0]        = instr;
      req_bl[BL_W-1:0]      = bl;
      req_addr[ADDR_W-1:0]  = addr;
      exp_q0.push_back(t);
    end else begin
      req_instr[5:3]              = instr;
      req_bl[2*BL_W-1:BL_W]       = bl;
      req_addr[2*ADDR_W-1:ADDR_W] = addr;
      exp_q1.push_back(t);
    end
    req[i]     = 1'b1;
    pending[i] = 1'b1;
  endtask

  task automatic new_txn(input int unsigned i, input bit misalign);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[1:0] = misalign ? 2'($urandom_range(3, 1)) : 2'b00;
    set_txn(i, 3'($urandom_range(1, 0)), BL_W'($urandom), a);
  endtask

  // One clock of agent activity; observes outputs and drives inputs on the falling edge.
  task automatic cycle();
    @(negedge clk);
    req_done = '0;
    for (int i = 0; i < 2; i++) begin
      if (busy[i]) begin
        cd[i]--;
        if (cd[i] == 0) begin
          busy[i] = 1'b0;
          req_done[i] = 1'b1;
        end
      end
      if (cmd_issued[i]) begin
        pending[i] = 1'b0;
        req[i]     = 1'b0;
        if (!no_done[i]) begin
          busy[i] = 1'b1;
          cd[i]   = $urandom_range(dly_hi, dly_lo);
        end
        if (refill) new_txn(i, 1'b0);
      end
      if (auto_new && !pending[i] && !busy[i] && ($urandom_range(99, 0) < new_pct))
        new_txn(i, $urandom_range(9, 0) == 0);
    end
    cmd_full = ($urandom_range(99, 0) < full_pct);
  endtask

  task automatic wait_grant(output int unsigned n);
    n = 0;
    do begin cycle(); n++; end while (grant == 2'b00 && n < 50);
  endtask

  task automatic wait_rise(output logic [1:0] g);
    int unsigned n = 0;
    while (grant != 2'b00 && n < 50) begin cycle(); n++; end
    while (grant == 2'b00 && n < 100) begin cycle(); n++; end
    g = grant;
  endtask

  task automatic wait_cmd(input string name);
    int unsigned n = 0;
    do begin cycle(); n++; end while (!cmd_en && n < 50);
    check(name, cmd_en, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    do begin cycle(); n++; end
    while ((grant != 2'b00 || pending[0] || pending[1] || busy[0] || busy[1]) && n < 300);
    check(name, n < 300, 1'b1);
  endtask

  // Monitor: scoreboard on cmd_en plus a round-robin winner model on each new grant.
  initial begin
    logic [1:0]  gprev;
    bit          mlast;
    txn_t        fprev;
    txn_t        e;
    logic [1:0]  exp_g;
    gprev = '0;
    mlast = 1'b1;
    fprev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        gprev = '0;
        mlast = 1'b1;
      end else begin
        if (gprev == 2'b00 && grant != 2'b00) begin
          if (req == 2'b00)      exp_g = 2'b00;
          else if (req == 2'b11) exp_g = mlast ? 2'b01 : 2'b10;
          else                   exp_g = req;
          check("rr_winner", grant, exp_g);
        end else if (gprev != 2'b00 && grant == gprev) begin
          check("fields_stable", {cmd_instr, cmd_bl, cmd_byte_addr}, fprev);
        end
        if (gprev != 2'b00 && grant == 2'b00) mlast = gprev[1];
        if (grant == 2'b11) check("grant_onehot", grant, 2'b00);
        if (cmd_en) begin
          check("en_vs_full", cmd_full, 1'b0);
          check("issued_owner", cmd_issued, grant);
          if (grant[1]) begin
            check("sb_nonempty1", exp_q1.size() > 0, 1'b1);
            if (exp_q1.size() > 0) begin
              e = exp_q1.pop_front();
              check("sb_cmd1", {cmd_instr, cmd_bl, cmd_byte_addr}, e);
            end
          end else begin
            check("sb_nonempty0", exp_q0.size() > 0, 1'b1);
            if (exp_q0.size() > 0) begin
              e = exp_q0.pop_front();
              check("sb_cmd0", {cmd_instr, cmd_bl, cmd_byte_addr}, e);
            end
          end
        end else if (cmd_issued != 2'b00) begin
          check("issued_no_en", cmd_issued, 2'b00);
        end
        gprev = grant;
        fprev = {cmd_instr, cmd_bl, cmd_byte_addr};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit          bad;
    logic [1:0]  seq[4];
    txn_t        snap;

    // Reset state
    repeat (3) cycle();
    check("rst_grant", grant, 2'b00);
    check("rst_cmd_en", cmd_en, 1'b0);
    check("rst_issued", cmd_issued, 2'b00);
    check("rst_fields", {cmd_instr, cmd_bl, cmd_byte_addr}, '0);
    check("rst_errs", {timeout_err, align_err}, 2'b00);
    check("rst_state", state_dbg, 2'd0);
    reset = 1'b1;

    // Calibration gating
    set_txn(0, 3'b001, BL_W'(7), ADDR_W'(32'h0000_1000));
    bad = 1'b0;
    repeat (20) begin
      cycle();
      if (grant != 2'b00 || cmd_en) bad = 1'b1;
    end
    check("cal_gate", bad, 1'b0);
    check("cal_state", state_dbg, 2'd0);
    mem_calib_done = 1'b1;
    wait_grant(n);
    check("cal_latency", n, 4);
    check("cal_grant", grant, 2'b01);
    wait_idle("cal_drain");

    // Round-robin with both requesting continuously, done 5 cycles after issue
    dly_lo = 5; dly_hi = 5; refill = 1'b1;
    new_txn(0, 1'b0);
    new_txn(1, 1'b0);
    for (int g = 0; g < 4; g++) wait_rise(seq[g]);
    check("rr_first", seq[0], 2'b10);
    for (int g = 1; g < 4; g++) check("rr_alt", seq[g], (seq[g-1] == 2'b01) ? 2'b10 : 2'b01);
    refill = 1'b0;
    wait_idle("rr_drain");

    // Backpressure in ISSUE
    dly_lo = 2; dly_hi = 2; full_pct = 100;
    new_txn(0, 1'b0);
    wait_grant(n);
    check("bp_state", state_dbg, 2'd2);
    snap = {cmd_instr, cmd_bl, cmd_byte_addr};
    bad = 1'b0;
    repeat (7) begin
      cycle();
      if (cmd_en) bad = 1'b1;
    end
    check("bp_no_en", bad, 1'b0);
    check("bp_fields", {cmd_instr, cmd_bl, cmd_byte_addr}, snap);
    full_pct = 0;
    cycle();
    cycle();
    check("bp_en", cmd_en, 1'b1);
    cycle();
    check("bp_en_once", cmd_en, 1'b0);
    wait_idle("bp_drain");

    // Misaligned address and a done from the non-owner
    check("align_pre", align_err, 1'b0);
    dly_lo = 6; dly_hi = 6;
    set_txn(0, 3'b000, BL_W'(63), ADDR_W'(32'h103));
    wait_grant(n);
    check("align_err", align_err, 1'b1);
    check("align_addr", cmd_byte_addr, ADDR_W'(32'h100));
    wait_cmd("align_cmd");
    req_done[1] = 1'b1;
    cycle();
    check("bad_done_ignored", grant, 2'b01);
    wait_idle("align_drain");

    // Done on the same cycle as the hold limit is a normal release
    dly_lo = HOLD_MAX - 1; dly_hi = HOLD_MAX - 1;
    new_txn(1, 1'b0);
    wait_idle("limit_drain");
    check("done_at_limit", timeout_err, 1'b0);

    // Timeout with no done, then the other requester is served
    dly_lo = 3; dly_hi = 3; no_done[0] = 1'b1;
    new_txn(0, 1'b0);
    wait_cmd("to_cmd");
    new_txn(1, 1'b0);
    n = 0;
    do begin cycle(); n++; end while (grant != 2'b00 && n < 40);
    check("to_cycles", n, HOLD_MAX);
    check("to_err", timeout_err, 1'b1);
    wait_grant(n);
    check("to_next", grant, 2'b10);
    no_done[0] = 1'b0;
    wait_idle("to_drain");

    // Randomized traffic
    auto_new = 1'b1; new_pct = 30; full_pct = 30; dly_lo = 1; dly_hi = 8;
    repeat (1500) cycle();
    auto_new = 1'b0; full_pct = 0;
    wait_idle("rand_drain");
    check("sb_drain", exp_q0.size() + exp_q1.size(), 0);

    // Asynchronous reset while holding
    dly_lo = 10; dly_hi = 10;
    new_txn(0, 1'b0);
    wait_cmd("ar_cmd");
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check("ar_grant", grant, 2'b00);
    check("ar_cmd_en", cmd_en, 1'b0);
    check("ar_state", state_dbg, 2'd0);
    check("ar_errs", {timeout_err, align_err}, 2'b00);
    check("ar_fields", {cmd_instr, cmd_bl, cmd_byte_addr}, '0);
    req = '0; req_done = '0;
    busy[0] = 1'b0; busy[1] = 1'b0; pending[0] = 1'b0; pending[1] = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    dly_lo = 2; dly_hi = 2;
    new_txn(1, 1'b0);
    wait_grant(n);
    check("ar_resync", n, 4);
    check("ar_grant_after", grant, 2'b10);
    wait_idle("ar_drain");
    check("sb_final", exp_q0.size() + exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
